// File: rtl/if_stream_loader_if.sv
// Loader bus bundle: source memory read port plus IF buffer write port.
// master = loader side, slave = memory / buffer side.
interface if_stream_loader_if #(
    parameter int DATA_WIDTH = 8,
    parameter int PAR_WRITE  = 2,
    parameter int ADDR_WIDTH = 10
);
    logic                                mem_ren;
    logic [ADDR_WIDTH-1:0]               mem_addr;
    logic [DATA_WIDTH-1:0]               mem_rdata;
    logic                                IF_full;
    logic                                IF_wen;
    logic [PAR_WRITE*(DATA_WIDTH+2)-1:0] IF_din;

    modport master (
        output mem_ren, mem_addr,
        input  mem_rdata,
        input  IF_full,
        output IF_wen, IF_din
    );

    modport slave (
        input  mem_ren, mem_addr,
        output mem_rdata,
        output IF_full,
        input  IF_wen, IF_din
    );
endinterface

// File: rtl/if_stream_loader.sv
// Streams row-structured words from a 1-cycle-latency memory into the
// IF buffer, PAR_WRITE lanes per write, tagging start/end of each row.
module if_stream_loader #(
    parameter int DATA_WIDTH = 8,
    parameter int PAR_WRITE  = 2,
    parameter int ADDR_WIDTH = 10,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [LEN_WIDTH-1:0]  row_len,
    input  logic [LEN_WIDTH-1:0]  row_count,
    if_stream_loader_if.master    bus,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);
    localparam int LW     = DATA_WIDTH + 2;
    localparam int IDX_W  = 2 * LEN_WIDTH;
    localparam int LANE_W = (PAR_WRITE > 1) ? $clog2(PAR_WRITE) : 1;

    typedef enum logic [2:0] {IDLE, FETCH, DRAIN, WRITE, DONE} state_e;

    state_e                        state_q, state_d;
    logic [ADDR_WIDTH-1:0]         base_q, base_d;
    logic [LEN_WIDTH-1:0]          len_q, len_d;
    logic [IDX_W-1:0]              total_q, total_d;
    logic [IDX_W-1:0]              idx_q, idx_d;
    logic [LEN_WIDTH-1:0]          col_q, col_d;
    logic [LANE_W-1:0]             lane_q, lane_d;
    logic                          cap_vld_q, cap_vld_d;
    logic [LANE_W-1:0]             cap_lane_q, cap_lane_d;
    logic                          cap_sor_q, cap_sor_d;
    logic                          cap_eor_q, cap_eor_d;
    logic [PAR_WRITE-1:0][LW-1:0]  lanes_q, lanes_d;
    logic                          err_q, err_d;

    logic bad_req;
    logic col_last;
    logic lane_last;

    assign bad_req   = (row_len == '0) || (row_count == '0) ||
                       ((row_len % LEN_WIDTH'(PAR_WRITE)) != '0);
    assign col_last  = (col_q == len_q - LEN_WIDTH'(1));
    assign lane_last = (lane_q == LANE_W'(PAR_WRITE - 1));

    assign busy         = (state_q != IDLE);
    assign done         = (state_q == DONE);
    assign err          = err_q;
    assign bus.mem_ren  = (state_q == FETCH);
    assign bus.mem_addr = (state_q == FETCH) ?
                          base_q + ADDR_WIDTH'(idx_q) : '0;
    assign bus.IF_wen   = (state_q == WRITE) && !bus.IF_full;
    assign bus.IF_din   = lanes_q;

    always_comb begin
        state_d    = state_q;
        base_d     = base_q;
        len_d      = len_q;
        total_d    = total_q;
        idx_d      = idx_q;
        col_d      = col_q;
        lane_d     = lane_q;
        cap_vld_d  = 1'b0;
        cap_lane_d = cap_lane_q;
        cap_sor_d  = cap_sor_q;
        cap_eor_d  = cap_eor_q;
        lanes_d    = lanes_q;
        err_d      = 1'b0;

        // Read data lands one cycle after its strobe; park it in its lane.
        for (int i = 0; i < PAR_WRITE; i++) begin
            if (cap_vld_q && cap_lane_q == LANE_W'(i)) begin
                lanes_d[i] = {cap_sor_q, cap_eor_q, bus.mem_rdata};
            end
        end

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    if (bad_req) begin
                        err_d = 1'b1;
                    end else begin
                        base_d  = base_addr;
                        len_d   = row_len;
                        total_d = IDX_W'(row_len) * IDX_W'(row_count);
                        idx_d   = '0;
                        col_d   = '0;
                        lane_d  = '0;
                        state_d = FETCH;
                    end
                end
            end
            FETCH: begin
                cap_vld_d  = 1'b1;
                cap_lane_d = lane_q;
                cap_sor_d  = (col_q == '0);
                cap_eor_d  = col_last;
                col_d      = col_last ? '0 : col_q + LEN_WIDTH'(1);
                idx_d      = idx_q + IDX_W'(1);
                if (lane_last) begin
                    lane_d  = '0;
                    state_d = DRAIN;
                end else begin
                    lane_d = lane_q + LANE_W'(1);
                end
            end
            DRAIN: state_d = WRITE;
            WRITE: begin
                if (!bus.IF_full) begin
                    state_d = (idx_q == total_q) ? DONE : FETCH;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            base_q     <= '0;
            len_q      <= '0;
            total_q    <= '0;
            idx_q      <= '0;
            col_q      <= '0;
            lane_q     <= '0;
            cap_vld_q  <= 1'b0;
            cap_lane_q <= '0;
            cap_sor_q  <= 1'b0;
            cap_eor_q  <= 1'b0;
            lanes_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            len_q      <= len_d;
            total_q    <= total_d;
            idx_q      <= idx_d;
            col_q      <= col_d;
            lane_q     <= lane_d;
            cap_vld_q  <= cap_vld_d;
            cap_lane_q <= cap_lane_d;
            cap_sor_q  <= cap_sor_d;
            cap_eor_q  <= cap_eor_d;
            lanes_q    <= lanes_d;
            err_q      <= err_d;
        end
    end
endmodule

// File: tb/tb_if_stream_loader.sv
// Directed bench for if_stream_loader: PAR_WRITE=2 and PAR_WRITE=1
// instances, memory returning address LSBs one cycle after each read.
module tb_if_stream_loader;
    logic       clk = 1'b0;
    logic       rst;
    logic       start, start1;
    logic [9:0] base;
    logic [7:0] len, cnt;
    logic       busy0, done0, err0;
    logic       busy1, done1, err1;
    int         ncmp  = 0;
    int         nfail = 0;
    int         nwen1 = 0;

    always #5 clk = ~clk;

    if_stream_loader_if #(.DATA_WIDTH(8), .PAR_WRITE(2), .ADDR_WIDTH(10)) bus0 ();
    if_stream_loader_if #(.DATA_WIDTH(8), .PAR_WRITE(1), .ADDR_WIDTH(10)) bus1 ();

    if_stream_loader #(
        .DATA_WIDTH(8), .PAR_WRITE(2), .ADDR_WIDTH(10), .LEN_WIDTH(8)
    ) u0 (
        .clk(clk), .rst(rst), .start(start), .base_addr(base),
        .row_len(len), .row_count(cnt), .bus(bus0),
        .busy(busy0), .done(done0), .err(err0)
    );

    if_stream_loader #(
        .DATA_WIDTH(8), .PAR_WRITE(1), .ADDR_WIDTH(10), .LEN_WIDTH(8)
    ) u1 (
        .clk(clk), .rst(rst), .start(start1), .base_addr(base),
        .row_len(len), .row_count(cnt), .bus(bus1),
        .busy(busy1), .done(done1), .err(err1)
    );

    // Memory model: word = address LSBs, one cycle latency.
    always @(posedge clk) if (bus0.mem_ren) bus0.mem_rdata <= bus0.mem_addr[7:0];
    always @(posedge clk) if (bus1.mem_ren) bus1.mem_rdata <= bus1.mem_addr[7:0];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic go(input logic [9:0] b, input logic [7:0] l, input logic [7:0] c);
        step(); start = 1'b1; base = b; len = l; cnt = c; #1;
        step(); start = 1'b0; #1;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; start1 = 1'b0;
        base = '0; len = '0; cnt = '0;
        bus0.IF_full = 1'b0; bus1.IF_full = 1'b0;
        step(); step(); #1;
        chk("rst_busy", 32'(busy0), 0);
        chk("rst_ren", 32'(bus0.mem_ren), 0);
        chk("rst_wen", 32'(bus0.IF_wen), 0);
        chk("rst_done", 32'(done0), 0);
        chk("rst_err", 32'(err0), 0);
        chk("rst_addr", 32'(bus0.mem_addr), 0);
        chk("rst_din", 32'(bus0.IF_din), 0);
        chk("rst_din1", 32'(bus1.IF_din), 0);
        step(); rst = 1'b0; #1;

        // Basic 4x1 transfer from 0x010
        go(10'h010, 8'd4, 8'd1);
        chk("a_ren1", 32'(bus0.mem_ren), 1);
        chk("a_addr1", 32'(bus0.mem_addr), 32'h010);
        chk("a_busy", 32'(busy0), 1);
        step(); #1;
        chk("a_addr2", 32'(bus0.mem_addr), 32'h011);
        step(); #1;
        chk("a_drain_ren", 32'(bus0.mem_ren), 0);
        chk("a_drain_wen", 32'(bus0.IF_wen), 0);
        step(); #1;
        chk("a_wen1", 32'(bus0.IF_wen), 1);
        chk("a_wen1_ren", 32'(bus0.mem_ren), 0);
        chk("a_din1", 32'(bus0.IF_din), 32'({10'h011, 10'h210}));
        step(); #1;
        chk("a_addr3", 32'(bus0.mem_addr), 32'h012);
        step(); #1;
        chk("a_addr4", 32'(bus0.mem_addr), 32'h013);
        step(); #1;
        step(); #1;
        chk("a_wen2", 32'(bus0.IF_wen), 1);
        chk("a_din2", 32'(bus0.IF_din), 32'({10'h113, 10'h012}));
        step(); #1;
        chk("a_done", 32'(done0), 1);
        step(); #1;
        chk("a_done_end", 32'(done0), 0);
        chk("a_idle", 32'(busy0), 0);

        // Same transfer, buffer full for 5 cycles on the first write
        go(10'h010, 8'd4, 8'd1);
        step(); #1;
        step(); bus0.IF_full = 1'b1; #1;
        for (int k = 4; k <= 8; k++) begin
            step(); #1;
            chk("b_stall_wen", 32'(bus0.IF_wen), 0);
            chk("b_stall_ren", 32'(bus0.mem_ren), 0);
            chk("b_stall_din", 32'(bus0.IF_din), 32'({10'h011, 10'h210}));
        end
        step(); bus0.IF_full = 1'b0; #1;
        chk("b_wen1", 32'(bus0.IF_wen), 1);
        chk("b_din1", 32'(bus0.IF_din), 32'({10'h011, 10'h210}));
        step(); #1;
        chk("b_addr3", 32'(bus0.mem_addr), 32'h012);
        step(); #1;
        step(); #1;
        step(); #1;
        chk("b_wen2", 32'(bus0.IF_wen), 1);
        chk("b_din2", 32'(bus0.IF_din), 32'({10'h113, 10'h012}));
        step(); #1;
        chk("b_done", 32'(done0), 1);

        // Rejected starts
        step(); #1;
        go(10'h010, 8'd3, 8'd1);
        chk("c_err_len", 32'(err0), 1);
        chk("c_busy_len", 32'(busy0), 0);
        chk("c_ren_len", 32'(bus0.mem_ren), 0);
        step(); #1;
        chk("c_err_len_end", 32'(err0), 0);
        chk("c_ren_len2", 32'(bus0.mem_ren), 0);
        go(10'h010, 8'd4, 8'd0);
        chk("c_err_cnt", 32'(err0), 1);
        chk("c_busy_cnt", 32'(busy0), 0);
        chk("c_ren_cnt", 32'(bus0.mem_ren), 0);
        step(); #1;
        chk("c_err_cnt_end", 32'(err0), 0);

        // Address wrap at top of memory
        go(10'h3FF, 8'd2, 8'd1);
        chk("d_addr1", 32'(bus0.mem_addr), 32'h3FF);
        step(); #1;
        chk("d_addr2", 32'(bus0.mem_addr), 32'h000);
        chk("d_ren2", 32'(bus0.mem_ren), 1);
        step(); #1;
        step(); #1;
        chk("d_din", 32'(bus0.IF_din), 32'({10'h100, 10'h2FF}));
        step(); #1;
        chk("d_done", 32'(done0), 1);

        // Reset during the second fetch of a 2x2 transfer
        go(10'h020, 8'd2, 8'd2);
        step(); #1;
        step(); #1;
        step(); #1;
        chk("e_wen1", 32'(bus0.IF_wen), 1);
        chk("e_din1", 32'(bus0.IF_din), 32'({10'h121, 10'h220}));
        step(); rst = 1'b1; #1;
        chk("e_fetch2", 32'(bus0.mem_addr), 32'h022);
        step(); rst = 1'b0; #1;
        chk("e_busy", 32'(busy0), 0);
        chk("e_ren", 32'(bus0.mem_ren), 0);
        chk("e_wen", 32'(bus0.IF_wen), 0);
        chk("e_done", 32'(done0), 0);
        chk("e_err", 32'(err0), 0);
        chk("e_addr", 32'(bus0.mem_addr), 0);
        chk("e_din", 32'(bus0.IF_din), 0);
        for (int k = 0; k < 3; k++) begin
            step(); #1;
            chk("e_quiet_done", 32'(done0), 0);
            chk("e_quiet_ren", 32'(bus0.mem_ren), 0);
        end
        go(10'h030, 8'd2, 8'd2);
        chk("e2_addr1", 32'(bus0.mem_addr), 32'h030);
        step(); #1;
        step(); #1;
        step(); #1;
        chk("e2_din1", 32'(bus0.IF_din), 32'({10'h131, 10'h230}));
        step(); #1;
        chk("e2_addr3", 32'(bus0.mem_addr), 32'h032);
        step(); #1;
        step(); #1;
        step(); #1;
        chk("e2_wen2", 32'(bus0.IF_wen), 1);
        chk("e2_din2", 32'(bus0.IF_din), 32'({10'h133, 10'h232}));
        step(); #1;
        chk("e2_done", 32'(done0), 1);

        // Reset wins over a simultaneous start
        step(); rst = 1'b1; start = 1'b1; base = 10'h010; len = 8'd4; cnt = 8'd1; #1;
        step(); rst = 1'b0; start = 1'b0; #1;
        chk("f_busy", 32'(busy0), 0);
        chk("f_ren", 32'(bus0.mem_ren), 0);
        step(); #1;
        chk("f_busy2", 32'(busy0), 0);

        // PAR_WRITE=1: three one-word rows
        step(); start1 = 1'b1; base = 10'h005; len = 8'd1; cnt = 8'd3; #1;
        for (int c = 1; c <= 11; c++) begin
            step(); start1 = 1'b0; #1;
            if (bus1.IF_wen) nwen1++;
            if (c == 3) chk("g_din1", 32'(bus1.IF_din), 32'h305);
            if (c == 6) chk("g_din2", 32'(bus1.IF_din), 32'h306);
            if (c == 9) chk("g_din3", 32'(bus1.IF_din), 32'h307);
            if (c == 9) chk("g_wen3", 32'(bus1.IF_wen), 1);
            if (c == 10) chk("g_done", 32'(done1), 1);
            if (c == 11) chk("g_idle", 32'(busy1), 0);
        end
        chk("g_wen_count", 32'(nwen1), 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end
endmodule

// File: doc/if_stream_loader.md
IF_STREAM_LOADER -- requirements
Module: if_stream_loader

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: width of one raw IF word (equals IF_SCRATCH_WIDTH).
REQ-002 SHALL have parameter PAR_WRITE, default 2: lanes per IF buffer write (equals IF_par_write).
REQ-003 SHALL have parameter ADDR_WIDTH, default 10: source memory address width.
REQ-004 SHALL have parameter LEN_WIDTH, default 8: width of the row_len and row_count inputs.
REQ-005 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-007 SHALL have port start, input, 1: one-cycle transfer request.
REQ-008 SHALL have port base_addr, input, ADDR_WIDTH: address of the first word.
REQ-009 SHALL have port row_len, input, LEN_WIDTH: words per row.
REQ-010 SHALL have port row_count, input, LEN_WIDTH: number of rows.
REQ-011 SHALL have port mem_ren, output, 1: source memory read strobe.
REQ-012 SHALL have port mem_addr, output, ADDR_WIDTH: source memory read address.
REQ-013 SHALL have port mem_rdata, input, DATA_WIDTH: read data, valid exactly 1 cycle after mem_ren.
REQ-014 SHALL have port IF_full, input, 1: IF buffer full.
REQ-015 SHALL have port IF_wen, output, 1: IF buffer write strobe.
REQ-016 SHALL have port IF_din, output, PAR_WRITE*(DATA_WIDTH+2): packed lanes, lane 0 in the LSBs.
REQ-017 SHALL have port busy, output, 1: high in any state other than IDLE.
REQ-018 SHALL have port done, output, 1: one-cycle pulse on transfer completion.
REQ-019 SHALL have port err, output, 1: one-cycle pulse on a rejected start.

Function
REQ-020 SHALL format each lane as {start-of-row, end-of-row, data}: bit DATA_WIDTH+1 = first word of a row, bit DATA_WIDTH = last word of a row; both set when row_len=1.
REQ-021 SHALL implement FSM states IDLE, FETCH, DRAIN, WRITE, DONE.
REQ-022 IDLE: on start with valid parameters, SHALL latch base_addr, row_len and row_count, clear the word/row counters, and go to FETCH.
REQ-023 SHALL reject a start when row_len=0, row_count=0, or row_len mod PAR_WRITE != 0: pulse err the next cycle, stay IDLE, issue no mem_ren.
REQ-024 FETCH: SHALL assert mem_ren for PAR_WRITE consecutive cycles; mem_addr = base_addr + linear word index, wrapping modulo 2^ADDR_WIDTH.
REQ-025 SHALL capture mem_rdata into lane i in the cycle after lane i's read.
REQ-026 After the last read, SHALL go to DRAIN for one cycle to capture the final lane, then to WRITE.
REQ-027 WRITE: SHALL assert IF_wen combinationally when IF_full=0, with IF_din stable for the whole WRITE stay.
REQ-028 While IF_full=1, SHALL hold WRITE with IF_wen=0, issuing no reads and leaving the lane contents unchanged.
REQ-029 After a write, SHALL go to FETCH if words remain, otherwise to DONE.
REQ-030 DONE: SHALL pulse done for one cycle, then return to IDLE.
REQ-031 SHALL ignore start while busy=1.
REQ-032 SHALL never assert mem_ren and IF_wen in the same cycle.
REQ-033 Total IF_wen pulses per transfer SHALL equal row_len*row_count/PAR_WRITE; rows never share a write group.

Reset
REQ-034 With rst=1 at a clock edge, SHALL enter IDLE and clear counters and lane registers; mem_ren, IF_wen, busy, done, err, mem_addr and IF_din all 0.
REQ-035 Reset asserted mid-transfer SHALL abort the transfer: no further mem_ren or IF_wen, and no done pulse.
REQ-036 rst SHALL take priority over a simultaneous start.

Verification
REQ-037 PAR_WRITE=2, DATA_WIDTH=8, base=0x010, row_len=4, row_count=1, memory word = address LSBs, IF_full=0, start at cycle 0 -> reads at 0x010/0x011 in cycles 1-2; IF_wen in cycle 4 with lane0=0x2_10, lane1=0x0_11; second write lane0=0x0_12, lane1=0x1_13; done pulse once.
REQ-038 Same setup with IF_full=1 for 5 cycles on the first write -> IF_wen delayed exactly 5 cycles, IF_din unchanged throughout, no mem_ren while stalled.
REQ-039 row_len=3 with PAR_WRITE=2; then row_count=0 -> err pulse each time, busy stays 0, no mem_ren.
REQ-040 base=0x3FF, row_len=2, row_count=1 -> mem_addr sequence 0x3FF, 0x000.
REQ-041 rst pulsed during the second FETCH of a 2x2 transfer -> all outputs 0 the next cycle, no done pulse; a new start afterwards completes normally.
REQ-042 PAR_WRITE=1, row_len=1, row_count=3 -> three IF_wen pulses, each lane with both flag bits set.
